// File: rtl/aer_event_fifo.sv
// AER event buffer: captures {timestamp, address} strobes into a FIFO and
// drains each event as two 32-bit words (address, then timestamp) over valid/ready.
module aer_event_fifo #(
   parameter int ADDR_W = 4,
   parameter int OVF_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              evt_valid,
   input  logic [31:0]       evt_addr,
   input  logic [31:0]       evt_time,
   output logic [31:0]       m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [ADDR_W:0]   fifo_level,
   output logic [OVF_W-1:0]  overflow_cnt,
   input  logic              clr_ovf
);

   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, W0, W1} state_t;

   state_t              state_q, state_d;
   logic [63:0]         mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [63:0]         head;
   logic [31:0]         time_hold;
   logic                fifo_full, fifo_empty;
   logic                wr_en, drop, pop;
   logic                unused_head_hi;

   // Fullness is judged on the pre-edge level, so a same-cycle pop never rescues a write.
   assign fifo_full      = (fifo_level == DEPTH_LVL);
   assign fifo_empty     = (fifo_level == '0);
   assign wr_en          = evt_valid && !fifo_full;
   assign drop           = evt_valid && fifo_full;
   assign head           = mem[rd_ptr];
   assign unused_head_hi = ^head[31:17];

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = W0;
            end
         end
         W0: begin
            if (m_ready) state_d = W1;
         end
         W1: begin
            if (m_ready) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = W0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {evt_time, evt_addr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + (ADDR_W+1)'(1);
            2'b01:   fifo_level <= fifo_level - (ADDR_W+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Timestamp of the in-flight event waits here until word 0 is accepted.
   always_ff @(posedge clk) begin
      if (pop) time_hold <= head[63:32];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (pop) begin
         m_data  <= {1'b1, 14'd0, head[16:0]};
         m_valid <= 1'b1;
         m_last  <= 1'b0;
      end else if (state_q == W0 && m_ready) begin
         m_data  <= time_hold;
         m_last  <= 1'b1;
      end else if (state_q == W1 && m_ready) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
      end else if (clr_ovf) begin
         overflow_cnt <= drop ? OVF_W'(1) : '0;
      end else if (drop && overflow_cnt != '1) begin
         overflow_cnt <= overflow_cnt + OVF_W'(1);
      end
   end

endmodule
